led_shift_arbiter: RTL and testbench

LED_SHIFT_ARBITER -- requirements
Module: led_shift_arbiter

---
 rtl/led_shift_arbiter.sv | 159 +++++++++++++++
 tb/tb_led_shift_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_arbiter.sv
// led_shift_arbiter: round-robin arbiter between a CPU and a debug port that
// serialises the granted 16-bit LED pattern MSB-first into an external shift
// register (led_clk/led_sout), then pulses LED_PEN to latch it.
module led_shift_arbiter #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_data,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic        led_clk,
  output logic        led_sout,
  output logic        led_clrn,
  output logic        LED_PEN,
  output logic [15:0] LED_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam logic [7:0] PH_LAST = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        rr_dbg_last_q, rr_dbg_last_d;
  logic [15:0] led_out_q, led_out_d;

  logic        phase_end;
  logic        gnt_cpu;
  logic        gnt_dbg;

  assign phase_end = (phase_q == PH_LAST);

  // Round-robin grant, only meaningful in IDLE; CPU wins ties unless it was served last.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (state_q == IDLE) begin
      gnt_cpu = cpu_req && (!dbg_req || rr_dbg_last_q);
      gnt_dbg = dbg_req && !gnt_cpu;
    end
  end

  // Next-state logic: phase timing, shifting, bit counting and latching.
  // After the 16th high phase one extra low phase is spent (last_q) before
  // LATCH, so the data hold time is met and LED_PEN never abuts led_clk high;
  // this gives the 34*DIV busy window.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_end ? '0 : phase_q + 8'd1;
    shift_d       = shift_q;
    word_d        = word_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    rr_dbg_last_d = rr_dbg_last_q;
    led_out_d     = led_out_q;
    case (state_q)
      CLR: begin
        if (phase_end) state_d = IDLE;
      end
      IDLE: begin
        phase_d = '0;
        if (gnt_cpu || gnt_dbg) begin
          shift_d       = gnt_cpu ? cpu_data : dbg_data;
          word_d        = gnt_cpu ? cpu_data : dbg_data;
          cnt_d         = 4'd15;
          last_d        = 1'b0;
          rr_dbg_last_d = gnt_dbg;
          state_d       = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          if (last_q) begin
            state_d   = LATCH;
            led_out_d = word_q;
          end else begin
            state_d = SHIFT_HI;
          end
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          state_d = SHIFT_LO;
          if (cnt_q == 4'd0) begin
            last_d = 1'b1;
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            cnt_d   = cnt_q - 4'd1;
          end
        end
      end
      LATCH: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  // State register with synchronous reset into CLR, CPU favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLR;
      phase_q       <= '0;
      shift_q       <= '0;
      word_q        <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      rr_dbg_last_q <= 1'b1;
      led_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      shift_q       <= shift_d;
      word_q        <= word_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      rr_dbg_last_q <= rr_dbg_last_d;
      led_out_q     <= led_out_d;
    end
  end

  // Outputs decoded from state; rst forces the safe values in the same cycle.
  always_comb begin
    cpu_ack  = 1'b0;
    dbg_ack  = 1'b0;
    led_clk  = 1'b0;
    led_sout = 1'b0;
    led_clrn = 1'b0;
    LED_PEN  = 1'b0;
    LED_out  = '0;
    busy     = 1'b1;
    if (!rst) begin
      cpu_ack  = gnt_cpu;
      dbg_ack  = gnt_dbg;
      led_clk  = (state_q == SHIFT_HI);
      led_sout = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && shift_q[15];
      led_clrn = (state_q != CLR);
      LED_PEN  = (state_q == LATCH);
      LED_out  = led_out_q;
      busy     = (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_led_shift_arbiter.sv
// Directed bench for led_shift_arbiter: one instance at DIV=2, one at DIV=1.
module tb_led_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_cpu_req, a_dbg_req;
  logic [15:0] a_cpu_data, a_dbg_data;
  logic        a_cack, a_dack, a_led_clk, a_led_sout, a_clrn, a_pen, a_busy;
  logic [15:0] a_out;

  logic        b_req;
  logic [15:0] b_data;
  logic        b_ack, b_dack, b_led_clk, b_led_sout, b_clrn, b_pen, b_busy;
  logic [15:0] b_out;

  led_shift_arbiter #(.DIV(2)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_data(a_cpu_data), .cpu_ack(a_cack),
    .dbg_req(a_dbg_req), .dbg_data(a_dbg_data), .dbg_ack(a_dack),
    .led_clk(a_led_clk), .led_sout(a_led_sout), .led_clrn(a_clrn),
    .LED_PEN(a_pen), .LED_out(a_out), .busy(a_busy)
  );

  led_shift_arbiter #(.DIV(1)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_req), .cpu_data(b_data), .cpu_ack(b_ack),
    .dbg_req(1'b0), .dbg_data(16'h0000), .dbg_ack(b_dack),
    .led_clk(b_led_clk), .led_sout(b_led_sout), .led_clrn(b_clrn),
    .LED_PEN(b_pen), .LED_out(b_out), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor counters, sampled on the falling edge.
  int cyc = 0, n_edge = 0, n_pen = 0, n_busy = 0, n_cack = 0, n_dack = 0, n_ack = 0;
  int n_overlap = 0, n_badack = 0, last_ack_cyc = 0, prev_ack_cyc = 0;
  int n_bedge = 0, n_bones = 0, n_bbusy = 0, n_btog = 0;
  logic [15:0] a_bits = '0;
  logic [7:0]  a_order = '0;
  logic [47:0] a_seq = '0;
  logic a_clk_prev = 1'b0, a_pen_prev = 1'b0, b_clk_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a_led_clk && !a_clk_prev) begin
      n_edge <= n_edge + 1;
      a_bits <= {a_bits[14:0], a_led_sout};
    end
    a_clk_prev <= a_led_clk;
    if (a_pen && !a_pen_prev) a_seq <= {a_seq[31:0], a_out};
    a_pen_prev <= a_pen;
    n_pen  <= n_pen + int'(a_pen);
    n_busy <= n_busy + int'(a_busy);
    n_cack <= n_cack + int'(a_cack);
    n_dack <= n_dack + int'(a_dack);
    if (a_cack || a_dack) begin
      n_ack        <= n_ack + 1;
      prev_ack_cyc <= last_ack_cyc;
      last_ack_cyc <= cyc;
      a_order      <= {a_order[5:0], a_cack, a_dack};
    end
    if (a_pen && a_led_clk) n_overlap <= n_overlap + 1;
    if ((a_cack && a_dack) || ((a_cack || a_dack) && a_busy)) n_badack <= n_badack + 1;
    if (b_led_clk && !b_clk_prev) begin
      n_bedge <= n_bedge + 1;
      if (b_led_sout) n_bones <= n_bones + 1;
    end
    if (b_led_clk != b_clk_prev) n_btog <= n_btog + 1;
    b_clk_prev <= b_led_clk;
    n_bbusy <= n_bbusy + int'(b_busy);
  end

  int s_edge, s_pen, s_busy, s_cack, s_dack, s_ack, s_bedge, s_bones, s_bbusy, s_btog;

  task automatic snap();
    s_edge = n_edge; s_pen = n_pen; s_busy = n_busy; s_cack = n_cack;
    s_dack = n_dack; s_ack = n_ack; s_bedge = n_bedge; s_bones = n_bones;
    s_bbusy = n_bbusy; s_btog = n_btog;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rises;
    logic pv;
    rst = 1'b1;
    a_cpu_req = 1'b0; a_dbg_req = 1'b0; a_cpu_data = '0; a_dbg_data = '0;
    b_req = 1'b0; b_data = '0;

    // Reset values
    step(3);
    @(negedge clk);
    check("reset_outs", {a_led_clk, a_led_sout, a_clrn, a_pen, a_cack, a_dack, a_busy}, 7'b0000001);
    check("reset_led_out", a_out, 16'h0000);
    check("reset_b", {b_clrn, b_busy}, 2'b01);

    // Release: CLR lasts DIV cycles, then IDLE
    step(1); rst = 1'b0;
    @(negedge clk); check("clr_cyc1", {a_clrn, a_busy}, 2'b01);
    @(negedge clk); check("clr_cyc2", {a_clrn, a_busy}, 2'b01);
    @(negedge clk); check("clr_idle", {a_clrn, a_busy}, 2'b10);

    // Single CPU transfer of A5C3
    step(1); snap();
    a_cpu_data = 16'hA5C3; a_cpu_req = 1'b1;
    @(negedge clk); check("xfer_ack", {a_cack, a_dack, a_busy}, 3'b100);
    step(1); a_cpu_req = 1'b0;
    step(75);
    check("xfer_cack_cnt", n_cack - s_cack, 1);
    check("xfer_edges", n_edge - s_edge, 16);
    check("xfer_bits", a_bits, 16'hA5C3);
    check("xfer_pen_cycles", n_pen - s_pen, 2);
    check("xfer_busy_cycles", n_busy - s_busy, 68);
    check("xfer_led_out", a_out, 16'hA5C3);

    // Short debug pulse and data changes while busy are ignored
    snap();
    a_cpu_data = 16'h1234; a_cpu_req = 1'b1;
    @(negedge clk); check("busy_ack", a_cack, 1'b1);
    step(1); a_cpu_req = 1'b0;
    step(10); a_dbg_data = 16'hFFFF; a_dbg_req = 1'b1; a_cpu_data = 16'h0000;
    step(1); a_dbg_req = 1'b0;
    step(70);
    check("busy_no_dack", n_dack - s_dack, 0);
    check("busy_one_xfer", n_busy - s_busy, 68);
    check("busy_bits", a_bits, 16'h1234);
    check("busy_led_out", a_out, 16'h1234);

    // Round-robin from reset with both requests held
    rst = 1'b1; step(2); rst = 1'b0; step(3);
    snap();
    a_cpu_data = 16'h0001; a_dbg_data = 16'h8000;
    a_cpu_req = 1'b1; a_dbg_req = 1'b1;
    for (int i = 0; i < 300 && (n_ack - s_ack) < 3; i++) step(1);
    a_cpu_req = 1'b0; a_dbg_req = 1'b0;
    check("rr_ack_count", n_ack - s_ack, 3);
    step(80);
    check("rr_order", a_order[5:0], 6'b10_01_10);
    check("rr_led_seq", a_seq, 48'h0001_8000_0001);
    check("rr_led_out", a_out, 16'h0001);

    // Back-to-back CPU requests held high
    snap();
    a_cpu_data = 16'h5A5A; a_cpu_req = 1'b1;
    for (int i = 0; i < 200 && (n_ack - s_ack) < 2; i++) step(1);
    a_cpu_req = 1'b0;
    check("b2b_ack_count", n_cack - s_cack, 2);
    check("b2b_gap", last_ack_cyc - prev_ack_cyc, 69);
    step(80);
    check("b2b_led_out", a_out, 16'h5A5A);

    // Reset at the 8th led_clk rising edge aborts the transfer
    snap();
    a_cpu_data = 16'hFFFF; a_cpu_req = 1'b1;
    step(1); a_cpu_req = 1'b0;
    rises = 0; pv = a_led_clk;
    for (int i = 0; i < 200 && rises < 8; i++) begin
      step(1);
      if (a_led_clk && !pv) rises++;
      pv = a_led_clk;
    end
    check("abort_found_edge8", rises, 8);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {a_led_clk, a_pen, a_clrn}, 3'b000);
    check("abort_led_out", a_out, 16'h0000);
    step(1); rst = 1'b0;
    @(negedge clk); check("abort_clr1", {a_clrn, a_busy}, 2'b01);
    @(negedge clk); check("abort_clr2", {a_clrn, a_busy}, 2'b01);
    @(negedge clk); check("abort_idle", {a_clrn, a_busy}, 2'b10);
    check("abort_no_latch", n_pen - s_pen, 0);
    check("abort_led_out_after", a_out, 16'h0000);

    // DIV=1 instance, all-ones pattern
    step(1); snap();
    b_data = 16'hFFFF; b_req = 1'b1;
    @(negedge clk); check("div1_ack", {b_ack, b_busy}, 2'b10);
    step(1); b_req = 1'b0;
    step(40);
    check("div1_edges", n_bedge - s_bedge, 16);
    check("div1_ones", n_bones - s_bones, 16);
    check("div1_busy", n_bbusy - s_bbusy, 34);
    check("div1_toggles", n_btog - s_btog, 32);
    check("div1_led_out", b_out, 16'hFFFF);

    // Global invariants over the whole run
    check("pen_clk_overlap", n_overlap, 0);
    check("ack_rules", n_badack, 0);
    check("div1_no_dbg_ack", b_dack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
